regfile_writeback: RTL and testbench

Write-side front end of the integer register file: merges results from the ALU path and the load/memory path onto the file's single write port (`write_address`, `write_data`, `RegWrite`). The ALU path is unbuffered and has priority. The memory path uses a valid/ready handshake into a small FIFO. A starvation guard guarantees memory results eventually retire. Sits between the execute/memory stages and `register_file`.

---
 rtl/rf_wb_pkg.sv | 15 +
 rtl/wb_sync_fifo.sv | 63 ++++++
 rtl/regfile_writeback.sv | 135 +++++++++++++
 tb/tb_regfile_writeback.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared definitions for the register-file write-back front end.
// Holds the default data width, register address width, the x0 encoding and
// the {rd, data} entry type carried by the memory-result path.
package rf_wb_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ADDR_W   = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]   rd;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_sync_fifo.sv
// wb_sync_fifo: synchronous FIFO buffering memory results ahead of the
// register-file write port.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high; empties the FIFO
//   push       enqueue push_data (caller guarantees !full)
//   push_data  entry to enqueue
//   pop        dequeue the head (caller guarantees !empty)
//   pop_data   current head entry (valid while !empty)
//   count      occupancy, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
module wb_sync_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = REG_ADDR_W + XLEN_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage is never reset; reset only clears the pointers, so stale
  // entries become unreachable.
  always_ff @(posedge clk) begin
    if (push) storage[wr_ptr] <= push_data;
  end

  assign pop_data = storage[rd_ptr];
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges the ALU result path and the buffered memory result
// path onto the register file's single write port.
// Optional feature macro: WB_STARVE_GUARD_EN builds the starvation counter that
// stalls the ALU so buffered memory results are guaranteed to retire. Without
// it alu_stall is tied low and memory results retire only in free cycles.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   alu_valid/rd/data    unbuffered ALU result (priority path)
//   alu_stall            upstream must hold the ALU result while high
//   mem_valid/rd/data    memory result offered into the FIFO
//   mem_ready            FIFO can accept a memory beat
//   write_address/data   register-file write port
//   RegWrite             register-file write strobe
//   fifo_count           current memory FIFO occupancy
module regfile_writeback
  import rf_wb_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alu_valid,
  input  logic [REG_ADDR_W-1:0]     alu_rd,
  input  logic [XLEN-1:0]           alu_data,
  output logic                      alu_stall,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [REG_ADDR_W-1:0]     mem_rd,
  input  logic [XLEN-1:0]           mem_data,
  output logic [REG_ADDR_W-1:0]     write_address,
  output logic [XLEN-1:0]           write_data,
  output logic                      RegWrite,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int EW = REG_ADDR_W + XLEN;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("regfile_writeback: DEPTH must be a power of two >= 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("regfile_writeback: STARVE_LIMIT must be >= 1");
  end

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [EW-1:0]         fifo_head;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  logic                  alu_win;

  // mem_ready comes only from registered occupancy, so there is no
  // combinational path from mem_valid.
  assign mem_ready = !fifo_full;
  assign fifo_push = mem_valid && !fifo_full;

  wb_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({mem_rd, mem_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_rd   = fifo_head[EW-1 -: REG_ADDR_W];
  assign head_data = fifo_head[XLEN-1:0];

  // Arbitration: a forced pop while stalled, then the ALU, then any pending
  // memory result. An ALU result aimed at x0 never claims the port.
  always_comb begin
    alu_win  = 1'b0;
    fifo_pop = 1'b0;
    if (alu_stall && !fifo_empty) begin
      fifo_pop = 1'b1;
    end else if (alu_valid && !alu_stall && alu_rd != REG_X0) begin
      alu_win = 1'b1;
    end else if (!fifo_empty) begin
      fifo_pop = 1'b1;
    end
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;

  // Counts consecutive arbitrations the waiting FIFO head lost to the ALU.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (fifo_pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (alu_win && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign alu_stall = (starve_cnt == LIMIT);
`else
  assign alu_stall = 1'b0;
`endif

  // ---- write-port register stage ----
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite      <= 1'b0;
      write_address <= REG_X0;
      write_data    <= '0;
    end else if (alu_win) begin
      RegWrite      <= 1'b1;
      write_address <= alu_rd;
      write_data    <= alu_data;
    end else if (fifo_pop) begin
      // A popped x0 beat retires silently.
      RegWrite      <= (head_rd != REG_X0);
      write_address <= head_rd;
      write_data    <= head_data;
    end else begin
      RegWrite      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
  import rf_wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic        RegWrite;
  logic [1:0]  fifo_count;

  int n_checks = 0;
  int n_pass   = 0;

  wb_entry_t mem_q[$];

  regfile_writeback dut (
    .clk           (clk),
    .reset         (reset),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .alu_stall     (alu_stall),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_rd        (mem_rd),
    .mem_data      (mem_data),
    .write_address (write_address),
    .write_data    (write_data),
    .RegWrite      (RegWrite),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: records what the DUT accepts at this edge, then checks the
  // write port against the scoreboard just after the edge.
  task automatic step();
    logic      rst_s, take_alu, acc_alu, acc_mem;
    wb_entry_t e;
    rst_s    = reset;
    take_alu = alu_valid && !alu_stall;
    acc_alu  = take_alu && (alu_rd != 5'd0) && !rst_s;
    acc_mem  = mem_valid && mem_ready && !rst_s;
    if (acc_mem && mem_rd != 5'd0) mem_q.push_back('{rd: mem_rd, data: mem_data});
    e = '{rd: alu_rd, data: alu_data};
    @(posedge clk);
    #1;
    if (take_alu) alu_valid = 1'b0;
    if (acc_mem)  mem_valid = 1'b0;
    if (rst_s) begin
      mem_q.delete();
    end else if (acc_alu) begin
      chk("alu_we",   RegWrite,      1'b1);
      chk("alu_addr", write_address, e.rd);
      chk("alu_data", write_data,    e.data);
    end else if (RegWrite) begin
      if (mem_q.size() == 0) begin
        chk("spurious_we", RegWrite, 1'b0);
      end else begin
        e = mem_q.pop_front();
        chk("mem_addr", write_address, e.rd);
        chk("mem_data", write_data,    e.data);
      end
    end
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
  endtask

  task automatic drive_mem(input logic [4:0] rd, input logic [31:0] d);
    mem_valid = 1'b1; mem_rd = rd; mem_data = d;
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;

    // Reset for two cycles, then one idle cycle.
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_we",    RegWrite,      1'b0);
    chk("rst_addr",  write_address, 5'd0);
    chk("rst_data",  write_data,    32'd0);
    chk("rst_ready", mem_ready,     1'b1);
    chk("rst_count", fifo_count,    2'd0);
    chk("rst_stall", alu_stall,     1'b0);

    // ALU write with one-cycle latency; x0 result never writes.
    drive_alu(5'd5, 32'hDEADBEEF);
    step();
    chk("alu5_addr", write_address, 5'd5);
    chk("alu5_data", write_data,    32'hDEADBEEF);
    drive_alu(5'd0, 32'h0000_0123);
    step();
    chk("alu_x0_we",   RegWrite,      1'b0);
    chk("alu_x0_hold", write_address, 5'd5);
    chk("alu_x0_dhold", write_data,   32'hDEADBEEF);

    // Back-to-back memory beats with the ALU idle.
    drive_mem(5'd3, 32'h11);
    step();
    chk("mem1_we_early", RegWrite,   1'b0);
    chk("mem1_count",    fifo_count, 2'd1);
    drive_mem(5'd4, 32'h22);
    step();
    chk("mem1_we",   RegWrite,      1'b1);
    chk("mem1_addr", write_address, 5'd3);
    step();
    chk("mem2_we",   RegWrite,      1'b1);
    chk("mem2_addr", write_address, 5'd4);
    chk("mem2_data", write_data,    32'h22);
    step();
    chk("mem_idle_we", RegWrite, 1'b0);

    // Fill the FIFO while the ALU keeps the port busy.
    drive_alu(5'd10, 32'hA0); drive_mem(5'd11, 32'hB1);
    step();
    drive_alu(5'd12, 32'hA2); drive_mem(5'd13, 32'hB3);
    step();
    chk("full_count", fifo_count, 2'd2);
    chk("full_ready", mem_ready,  1'b0);
    drive_alu(5'd14, 32'hA4); drive_mem(5'd15, 32'hB5);
    step();
    chk("held_ready", mem_ready,  1'b0);
    chk("held_count", fifo_count, 2'd2);
    step();
    chk("drain1_addr",  write_address, 5'd11);
    chk("drain1_count", fifo_count,    2'd1);
    chk("drain1_ready", mem_ready,     1'b1);
    step();
    chk("drain2_addr",  write_address, 5'd13);
    chk("drain2_count", fifo_count,    2'd1);
    step();
    chk("drain3_addr",  write_address, 5'd15);
    chk("drain3_data",  write_data,    32'hB5);
    chk("drain3_count", fifo_count,    2'd0);

    // ALU valid every cycle while a memory result waits.
    drive_alu(5'd20, 32'hC1); drive_mem(5'd7, 32'h77);
    step();
    for (int i = 2; i <= 5; i++) begin
      drive_alu(5'(20 + i), 32'hC0 + 32'(i));
      step();
`ifdef WB_STARVE_GUARD_EN
      chk("starve_stall", alu_stall, (i == 5));
`else
      chk("noguard_stall", alu_stall,  1'b0);
      chk("noguard_count", fifo_count, 2'd1);
`endif
    end
    drive_alu(5'd26, 32'hC6);
    step();
`ifdef WB_STARVE_GUARD_EN
    chk("forced_pop_addr", write_address, 5'd7);
    chk("forced_pop_data", write_data,    32'h77);
    chk("stall_clear",     alu_stall,     1'b0);
    step();
    chk("held_alu_addr", write_address, 5'd26);
`else
    chk("noguard_alu_addr", write_address, 5'd26);
    step();
    chk("noguard_pop_addr", write_address, 5'd7);
`endif

    // Reset with two buffered entries and a write in flight.
    drive_alu(5'd30, 32'hD0); drive_mem(5'd31, 32'hE1);
    step();
    drive_alu(5'd1, 32'hD2); drive_mem(5'd2, 32'hE3);
    step();
    chk("prerst_count", fifo_count, 2'd2);
    chk("prerst_we",    RegWrite,   1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_we",    RegWrite,   1'b0);
    chk("midrst_count", fifo_count, 2'd0);
    chk("midrst_ready", mem_ready,  1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("postrst_we", RegWrite, 1'b0);
    end

    // Mixed random traffic; valid is held until each beat is taken.
    for (int i = 0; i < 60; i++) begin
      if (!alu_valid && $urandom_range(0, 1) == 1)
        drive_alu(5'($urandom_range(0, 31)), $urandom);
      if (!mem_valid && $urandom_range(0, 2) != 0)
        drive_mem(5'($urandom_range(0, 31)), $urandom);
      step();
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    for (int i = 0; i < 30 && (mem_q.size() != 0 || fifo_count != 2'd0); i++) step();
    chk("drain_queue", mem_q.size(), 0);
    chk("drain_count", fifo_count,   2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
